data_stack_ctl: RTL and testbench



---
 rtl/data_stack_pkg.sv | 50 +++++
 rtl/dstack_mem.sv | 44 ++++
 rtl/data_stack_ctl.sv | 184 ++++++++++++++++++
 tb/tb_data_stack_ctl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared op encoding, default sizes and op-requirement helpers for the data stack.
// DSTACK_ROT_EN remaps op code 7 from OVER to ROT.
package data_stack_pkg;

  localparam int DSTACK_DATA_W_DEF = 4;
  localparam int DSTACK_DEPTH_DEF  = 16;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_PUSH    = 3'd1,
    OP_POP     = 3'd2,
    OP_REPLACE = 3'd3,
    OP_DUP     = 3'd4,
    OP_DROP    = 3'd5,
    OP_SWAP    = 3'd6,
`ifdef DSTACK_ROT_EN
    OP_ROT     = 3'd7
`else
    OP_OVER    = 3'd7
`endif
  } dstack_op_e;

  // Minimum number of entries that must already be on the stack.
  function automatic logic [1:0] dstack_need(input dstack_op_e op);
    case (op)
      OP_POP, OP_REPLACE, OP_DUP, OP_DROP: return 2'd1;
`ifdef DSTACK_ROT_EN
      OP_SWAP: return 2'd2;
      OP_ROT:  return 2'd3;
`else
      OP_SWAP, OP_OVER: return 2'd2;
`endif
      default: return 2'd0;
    endcase
  endfunction

  // Net change in occupancy when the op is accepted.
  function automatic logic signed [1:0] dstack_grow(input dstack_op_e op);
    case (op)
`ifdef DSTACK_ROT_EN
      OP_PUSH, OP_DUP: return 2'sd1;
`else
      OP_PUSH, OP_DUP, OP_OVER: return 2'sd1;
`endif
      OP_POP, OP_DROP: return -2'sd1;
      default:         return 2'sd0;
    endcase
  endfunction

endpackage

// File: rtl/dstack_mem.sv
// DEPTH x DATA_W register array: three async read ports, two sync write ports
// (a third write port exists only with DSTACK_ROT_EN). Later ports win on collision.
module dstack_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_a_i,
  input  logic [AW-1:0]     waddr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  input  logic              we_b_i,
  input  logic [AW-1:0]     waddr_b_i,
  input  logic [DATA_W-1:0] wdata_b_i,
`ifdef DSTACK_ROT_EN
  input  logic              we_c_i,
  input  logic [AW-1:0]     waddr_c_i,
  input  logic [DATA_W-1:0] wdata_c_i,
`endif
  input  logic [AW-1:0]     raddr_0_i,
  input  logic [AW-1:0]     raddr_1_i,
  input  logic [AW-1:0]     raddr_2_i,
  output logic [DATA_W-1:0] rdata_0_o,
  output logic [DATA_W-1:0] rdata_1_o,
  output logic [DATA_W-1:0] rdata_2_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; occupancy gating hides stale entries, and leaving
  // it out keeps the array as plain flops without a reset tree.
  always_ff @(posedge clk) begin
    if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
    if (we_b_i) mem_q[waddr_b_i] <= wdata_b_i;
`ifdef DSTACK_ROT_EN
    if (we_c_i) mem_q[waddr_c_i] <= wdata_c_i;
`endif
  end

  assign rdata_0_o = mem_q[raddr_0_i];
  assign rdata_1_o = mem_q[raddr_1_i];
  assign rdata_2_o = mem_q[raddr_2_i];

endmodule

// File: rtl/data_stack_ctl.sv
// Parametrised data stack with Forth-style ops, occupancy and sticky error flags.
// DSTACK_ROT_EN: op 7 becomes ROT (replaces OVER) and adds the nntos output.
module data_stack_ctl
  import data_stack_pkg::*;
#(
  parameter int DATA_W = DSTACK_DATA_W_DEF,
  parameter int DEPTH  = DSTACK_DEPTH_DEF,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] push_data,
  input  logic              err_clr,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] ntos,
`ifdef DSTACK_ROT_EN
  output logic [DATA_W-1:0] nntos,
`endif
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int AW = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              has1, has2, has3, full_w;
  logic [AW-1:0]     idx1, idx2, idx3;
  logic [DATA_W-1:0] rd1, rd2, rd3;
  logic [DATA_W-1:0] tos_w, ntos_w, nntos_w;

  dstack_op_e        op_e;
  logic [1:0]        need;
  logic signed [1:0] grow;
  logic              short_w, no_room, accept;

  logic              we_a, we_b;
  logic [AW-1:0]     wa_a, wa_b;
  logic [DATA_W-1:0] wd_a, wd_b;
`ifdef DSTACK_ROT_EN
  logic              we_c;
  logic [AW-1:0]     wa_c;
  logic [DATA_W-1:0] wd_c;
`endif

  assign has1   = count_q >= CNT_W'(1);
  assign has2   = count_q >= CNT_W'(2);
  assign has3   = count_q >= CNT_W'(3);
  assign full_w = count_q == CNT_W'(DEPTH);

  // Read addresses are clamped so a short stack never indexes past the array.
  assign idx1 = has1 ? AW'(count_q - CNT_W'(1)) : '0;
  assign idx2 = has2 ? AW'(count_q - CNT_W'(2)) : '0;
  assign idx3 = has3 ? AW'(count_q - CNT_W'(3)) : '0;

  dstack_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk       (clk),
    .we_a_i    (we_a),
    .waddr_a_i (wa_a),
    .wdata_a_i (wd_a),
    .we_b_i    (we_b),
    .waddr_b_i (wa_b),
    .wdata_b_i (wd_b),
`ifdef DSTACK_ROT_EN
    .we_c_i    (we_c),
    .waddr_c_i (wa_c),
    .wdata_c_i (wd_c),
`endif
    .raddr_0_i (idx1),
    .raddr_1_i (idx2),
    .raddr_2_i (idx3),
    .rdata_0_o (rd1),
    .rdata_1_o (rd2),
    .rdata_2_o (rd3)
  );

  assign tos_w   = has1 ? rd1 : '0;
  assign ntos_w  = has2 ? rd2 : '0;
  assign nntos_w = has3 ? rd3 : '0;

  assign op_e    = dstack_op_e'(op);
  assign need    = dstack_need(op_e);
  assign grow    = dstack_grow(op_e);
  assign short_w = count_q < CNT_W'(need);
  assign no_room = (grow == 2'sd1) && full_w;
  assign accept  = !short_w && !no_room;

  // NOTE: every signal gets its default before the case so no path infers a latch.
  always_comb begin
    count_d     = count_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    we_a = 1'b0; wa_a = '0; wd_a = '0;
    we_b = 1'b0; wa_b = '0; wd_b = '0;
`ifdef DSTACK_ROT_EN
    we_c = 1'b0; wa_c = '0; wd_c = '0;
`endif

    if (accept) begin
      if (grow == 2'sd1)       count_d = count_q + CNT_W'(1);
      else if (grow == -2'sd1) count_d = count_q - CNT_W'(1);

      case (op_e)
        OP_PUSH: begin
          we_a = 1'b1; wa_a = AW'(count_q); wd_a = push_data;
        end
        OP_POP: begin
          pop_data_d  = tos_w;
          pop_valid_d = 1'b1;
        end
        OP_REPLACE: begin
          we_a = 1'b1; wa_a = idx1; wd_a = push_data;
        end
        OP_DUP: begin
          we_a = 1'b1; wa_a = AW'(count_q); wd_a = tos_w;
        end
        OP_SWAP: begin
          we_a = 1'b1; wa_a = idx1; wd_a = ntos_w;
          we_b = 1'b1; wa_b = idx2; wd_b = tos_w;
        end
`ifdef DSTACK_ROT_EN
        OP_ROT: begin
          we_a = 1'b1; wa_a = idx3; wd_a = ntos_w;
          we_b = 1'b1; wa_b = idx2; wd_b = tos_w;
          we_c = 1'b1; wa_c = idx1; wd_c = nntos_w;
        end
`else
        OP_OVER: begin
          we_a = 1'b1; wa_a = AW'(count_q); wd_a = ntos_w;
        end
`endif
        default: ;
      endcase
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    ovf_d = (ovf_q & ~err_clr) | no_room;
    unf_d = (unf_q & ~err_clr) | short_w;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      count_q     <= count_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign pop_data      = pop_data_q;
  assign pop_valid     = pop_valid_q;
  assign tos           = tos_w;
  assign ntos          = ntos_w;
  assign count         = count_q;
  assign empty         = !has1;
  assign full          = full_w;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

`ifdef DSTACK_ROT_EN
  assign nntos = nntos_w;
`else
  logic [DATA_W-1:0] nntos_unused;
  assign nntos_unused = nntos_w;
`endif

endmodule

// File: tb/tb_data_stack_ctl.sv
// Directed plus randomized bench for data_stack_ctl against a queue-based stack model.
module tb_data_stack_ctl;
  import data_stack_pkg::*;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        op;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [DATA_W-1:0] tos, ntos;
`ifdef DSTACK_ROT_EN
  logic [DATA_W-1:0] nntos;
`endif
  logic [CNT_W-1:0]  count;
  logic              empty, full, overflow_err, underflow_err;

  data_stack_ctl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .op            (op),
    .push_data     (push_data),
    .err_clr       (err_clr),
    .pop_data      (pop_data),
    .pop_valid     (pop_valid),
    .tos           (tos),
    .ntos          (ntos),
`ifdef DSTACK_ROT_EN
    .nntos         (nntos),
`endif
    .count         (count),
    .empty         (empty),
    .full          (full),
    .overflow_err  (overflow_err),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: the stack as a queue, back = top of stack.
  logic [DATA_W-1:0] stk [$];
  logic              m_ovf = 1'b0, m_unf = 1'b0, m_pv = 1'b0;
  logic [DATA_W-1:0] m_pd = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] m_entry(input int depth_from_top);
    int n = stk.size();
    return (n > depth_from_top) ? stk[n-1-depth_from_top] : '0;
  endfunction

  task automatic model_step(input logic [2:0] o, input logic [DATA_W-1:0] d,
                            input logic clr, input logic r);
    int n;
    logic new_o, new_u;
    logic [DATA_W-1:0] t;
    if (r) begin
      stk.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_pv = 1'b0; m_pd = '0;
      return;
    end
    n = stk.size();
    new_o = 1'b0; new_u = 1'b0; m_pv = 1'b0;
    case (o)
      OP_PUSH:    if (n >= DEPTH) new_o = 1'b1; else stk.push_back(d);
      OP_POP:     if (n < 1) new_u = 1'b1; else begin m_pd = stk.pop_back(); m_pv = 1'b1; end
      OP_REPLACE: if (n < 1) new_u = 1'b1; else stk[n-1] = d;
      OP_DUP:     if (n < 1) new_u = 1'b1; else if (n >= DEPTH) new_o = 1'b1;
                  else stk.push_back(stk[n-1]);
      OP_DROP:    if (n < 1) new_u = 1'b1; else void'(stk.pop_back());
      OP_SWAP:    if (n < 2) new_u = 1'b1;
                  else begin t = stk[n-1]; stk[n-1] = stk[n-2]; stk[n-2] = t; end
`ifdef DSTACK_ROT_EN
      OP_ROT:     if (n < 3) new_u = 1'b1;
                  else begin t = stk[n-3]; stk.delete(n-3); stk.push_back(t); end
`else
      OP_OVER:    if (n < 2) new_u = 1'b1; else if (n >= DEPTH) new_o = 1'b1;
                  else stk.push_back(stk[n-2]);
`endif
      default: ;
    endcase
    m_ovf = (m_ovf && !clr) || new_o;
    m_unf = (m_unf && !clr) || new_u;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, count, stk.size());
    chk({tag, ".tos"}, tos, m_entry(0));
    chk({tag, ".ntos"}, ntos, m_entry(1));
`ifdef DSTACK_ROT_EN
    chk({tag, ".nntos"}, nntos, m_entry(2));
`endif
    chk({tag, ".empty"}, empty, stk.size() == 0);
    chk({tag, ".full"}, full, stk.size() == DEPTH);
    chk({tag, ".ovf"}, overflow_err, m_ovf);
    chk({tag, ".unf"}, underflow_err, m_unf);
    chk({tag, ".pv"}, pop_valid, m_pv);
    chk({tag, ".pd"}, pop_data, m_pd);
  endtask

  // One clock: drive, let the edge happen, advance the model, sample 1 ns later.
  task automatic step(input string tag, input logic [2:0] o, input logic [DATA_W-1:0] d = '0,
                      input logic clr = 1'b0, input logic r = 1'b0);
    rst = r; op = o; push_data = d; err_clr = clr;
    @(posedge clk);
    model_step(o, d, clr, r);
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; op = OP_NOP; push_data = '0; err_clr = 1'b0;

    // Reset state and basic push/pop
    step("rst", OP_NOP, '0, 1'b0, 1'b1);
    chk("rst.count_c", count, 0);
    chk("rst.flags_c", {overflow_err, underflow_err, pop_valid}, 0);
    chk("rst.pd_c", pop_data, 0);
    step("push3", OP_PUSH, 4'h3);
    step("push5", OP_PUSH, 4'h5);
    chk("pp.count_c", count, 2);
    chk("pp.tos_c", tos, 4'h5);
    chk("pp.ntos_c", ntos, 4'h3);
    chk("pp.empty_c", empty, 1'b0);
    step("pop", OP_POP);
    chk("pop.pv_c", pop_valid, 1'b1);
    chk("pop.pd_c", pop_data, 4'h5);
    chk("pop.tos_c", tos, 4'h3);
    step("pop.idle", OP_NOP);
    chk("pop.idle_pv_c", pop_valid, 1'b0);
    chk("pop.idle_pd_c", pop_data, 4'h5);

    // Fill to DEPTH, then overflow attempts
    step("rst2", OP_NOP, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step("fill", OP_PUSH, DATA_W'(i));
    chk("fill.full_c", full, 1'b1);
    step("push_full", OP_PUSH, 4'hA);
    chk("ovf.flag_c", overflow_err, 1'b1);
    chk("ovf.tos_c", tos, 4'hF);
    chk("ovf.count_c", count, DEPTH);
    step("clr_ovf", OP_NOP, '0, 1'b1);
    chk("clr_ovf.flag_c", overflow_err, 1'b0);
    step("dup_full", OP_DUP);
    chk("dup_full.ovf_c", overflow_err, 1'b1);
    chk("dup_full.count_c", count, DEPTH);

    // Underflow and err_clr interaction
    step("rst3", OP_NOP, '0, 1'b0, 1'b1);
    step("pop_empty", OP_POP);
    chk("unf.flag_c", underflow_err, 1'b1);
    chk("unf.pv_c", pop_valid, 1'b0);
    chk("unf.tos_c", tos, 0);
    step("clr_unf", OP_NOP, '0, 1'b1);
    step("repl_empty", OP_REPLACE, 4'h9);
    chk("repl_empty.unf_c", underflow_err, 1'b1);
    step("clr_both", OP_NOP, '0, 1'b1);
    chk("clr_both.flags_c", {overflow_err, underflow_err}, 0);
    step("clr_and_pop", OP_POP, '0, 1'b1);
    chk("clr_and_pop.unf_c", underflow_err, 1'b1);

    // Manipulation ops on stack 1 2
    step("rst4", OP_NOP, '0, 1'b0, 1'b1);
    step("push1", OP_PUSH, 4'h1);
    step("push2", OP_PUSH, 4'h2);
    step("swap", OP_SWAP);
    chk("swap.tos_c", tos, 4'h1);
    chk("swap.ntos_c", ntos, 4'h2);
`ifndef DSTACK_ROT_EN
    step("over", OP_OVER);
    chk("over.count_c", count, 3);
    chk("over.tos_c", tos, 4'h2);
    chk("over.ntos_c", ntos, 4'h1);
    step("dup", OP_DUP);
    chk("dup.tos_c", tos, 4'h2);
    chk("dup.ntos_c", ntos, 4'h2);
    step("drop", OP_DROP);
    chk("drop.count_c", count, 3);
    chk("drop.pv_c", pop_valid, 1'b0);
`endif

    // REPLACE, then reset colliding with PUSH
    step("rst5", OP_NOP, '0, 1'b0, 1'b1);
    step("unf_pre", OP_POP);
    step("push7", OP_PUSH, 4'h7);
    step("push8", OP_PUSH, 4'h8);
    step("push9", OP_PUSH, 4'h9);
    step("replace", OP_REPLACE, 4'hC);
    chk("replace.tos_c", tos, 4'hC);
    chk("replace.count_c", count, 3);
    step("rst_push", OP_PUSH, 4'h4, 1'b0, 1'b1);
    chk("rst_push.count_c", count, 0);
    chk("rst_push.flags_c", {overflow_err, underflow_err, pop_valid}, 0);
    chk("rst_push.tos_c", tos, 0);

`ifdef DSTACK_ROT_EN
    step("push1r", OP_PUSH, 4'h1);
    step("push2r", OP_PUSH, 4'h2);
    step("push3r", OP_PUSH, 4'h3);
    step("rot", OP_ROT);
    chk("rot.tos_c", tos, 4'h1);
    chk("rot.ntos_c", ntos, 4'h3);
    chk("rot.nntos_c", nntos, 4'h2);
    step("rst6", OP_NOP, '0, 1'b0, 1'b1);
    step("push1s", OP_PUSH, 4'h1);
    step("push2s", OP_PUSH, 4'h2);
    step("rot_short", OP_ROT);
    chk("rot_short.unf_c", underflow_err, 1'b1);
`endif

    // Randomized traffic, push-biased so the full boundary is also reached
    for (int i = 0; i < 800; i++) begin
      logic [2:0] ro;
      ro = ($urandom_range(0, 9) < 3) ? 3'(OP_PUSH) : 3'($urandom_range(0, 7));
      step("rand", ro, DATA_W'($urandom_range(0, 15)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 149) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
